// File: rtl/axis_width_serializer.sv
// AXI4-Stream width downconverter: wide beats with tkeep in, one kept byte per beat out.
// A single holding register feeds the output directly; null bytes are skipped in zero cycles.
module axis_width_serializer #(
   parameter int S_DATA_WIDTH = 32,
   parameter int S_KEEP_WIDTH = S_DATA_WIDTH / 8,
   parameter int USER_WIDTH   = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [S_KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic                    s_axis_tlast,
   input  logic [USER_WIDTH-1:0]   s_axis_tuser,
   output logic [7:0]              m_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tlast,
   output logic [USER_WIDTH-1:0]   m_axis_tuser,
   output logic                    status_empty_last
);

   localparam int IDX_W = $clog2(S_KEEP_WIDTH);
   localparam logic [S_KEEP_WIDTH-1:0] ONE = S_KEEP_WIDTH'(1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                             state;
   logic [S_KEEP_WIDTH-1:0][7:0]       data_q;
   logic [S_KEEP_WIDTH-1:0]            keep_q;
   logic                               last_q;
   logic [USER_WIDTH-1:0]              user_q;
   logic                               empty_last_q;

   logic [IDX_W-1:0] idx;
   logic             one_left;
   logic             s_fire;
   logic             m_fire;

   function automatic logic [IDX_W-1:0] low_idx(input logic [S_KEEP_WIDTH-1:0] k);
      low_idx = '0;
      for (int i = S_KEEP_WIDTH - 1; i >= 0; i--) begin
         if (k[i]) low_idx = IDX_W'(i);
      end
   endfunction

   // Remaining mask has exactly one bit set: current byte closes the beat.
   assign idx      = low_idx(keep_q);
   assign one_left = ((keep_q & (keep_q - ONE)) == '0);

   assign m_axis_tvalid = (state == SHIFT);
   assign m_axis_tdata  = m_axis_tvalid ? data_q[idx] : 8'h00;
   assign m_axis_tlast  = m_axis_tvalid & one_left & last_q;
   assign m_axis_tuser  = (m_axis_tvalid & one_left) ? user_q : '0;

   assign s_axis_tready = rst_n &
                          ((state == IDLE) |
                           ((state == SHIFT) & m_axis_tready & one_left));

   assign s_fire = s_axis_tvalid & s_axis_tready;
   assign m_fire = m_axis_tvalid & m_axis_tready;

   assign status_empty_last = empty_last_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         data_q       <= '0;
         keep_q       <= '0;
         last_q       <= 1'b0;
         user_q       <= '0;
         empty_last_q <= 1'b0;
      end else begin
         empty_last_q <= s_fire & (s_axis_tkeep == '0) & s_axis_tlast;
         if (m_fire) begin
            keep_q <= keep_q & (keep_q - ONE);
            if (one_left) state <= IDLE;
         end
         if (s_fire && (s_axis_tkeep != '0)) begin
            data_q <= s_axis_tdata;
            keep_q <= s_axis_tkeep;
            last_q <= s_axis_tlast;
            user_q <= s_axis_tuser;
            state  <= SHIFT;
         end
      end
   end

endmodule

// File: tb/tb_axis_width_serializer.sv
// Bench for axis_width_serializer: directed scenarios plus random traffic
// checked against a byte-queue reference model.
module tb_axis_width_serializer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] s_tdata;
   logic [3:0]  s_tkeep;
   logic        s_tvalid;
   logic        s_tready;
   logic        s_tlast;
   logic [0:0]  s_tuser;
   logic [7:0]  m_tdata;
   logic        m_tvalid;
   logic        m_tready;
   logic        m_tlast;
   logic [0:0]  m_tuser;
   logic        status_empty_last;

   int n_pass = 0;
   int n_total = 0;

   logic [9:0] q[$];
   logic       exp_pulse = 1'b0;

   always #5 clk = ~clk;

   axis_width_serializer #(.S_DATA_WIDTH(32), .USER_WIDTH(1)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .s_axis_tdata(s_tdata),
      .s_axis_tkeep(s_tkeep),
      .s_axis_tvalid(s_tvalid),
      .s_axis_tready(s_tready),
      .s_axis_tlast(s_tlast),
      .s_axis_tuser(s_tuser),
      .m_axis_tdata(m_tdata),
      .m_axis_tvalid(m_tvalid),
      .m_axis_tready(m_tready),
      .m_axis_tlast(m_tlast),
      .m_axis_tuser(m_tuser),
      .status_empty_last(status_empty_last)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   // Expected output bytes of one beat: {tlast, tuser, data}, in byte order.
   task automatic push_beat(input logic [31:0] d, input logic [3:0] k,
                            input logic l, input logic u);
      int hi;
      hi = -1;
      for (int i = 0; i < 4; i++) if (k[i]) hi = i;
      for (int i = 0; i < 4; i++) begin
         if (k[i]) q.push_back({(i == hi) & l, (i == hi) & u, d[8*i +: 8]});
      end
   endtask

   task automatic step(input logic v, input logic [31:0] d, input logic [3:0] k,
                       input logic l, input logic u, input logic mr);
      logic sf;
      logic mf;
      @(negedge clk);
      s_tvalid = v;
      s_tdata  = d;
      s_tkeep  = k;
      s_tlast  = l;
      s_tuser  = u;
      m_tready = mr;
      #1;
      check("status_empty_last", 32'(status_empty_last), 32'(exp_pulse));
      exp_pulse = 1'b0;
      check("m_tvalid", 32'(m_tvalid), 32'(q.size() != 0));
      if (q.size() != 0)
         check("m_byte", 32'({m_tlast, m_tuser, m_tdata}), 32'(q[0]));
      check("s_tready", 32'(s_tready),
            32'((q.size() == 0) || (mr && q.size() == 1)));
      sf = v & s_tready;
      mf = m_tvalid & mr;
      if (mf && q.size() != 0) void'(q.pop_front());
      if (sf) begin
         if (k == 4'h0) exp_pulse = l;
         else push_beat(d, k, l, u);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      rst_n    = 1'b0;
      s_tvalid = 1'b0;
      s_tdata  = '0;
      s_tkeep  = '0;
      s_tlast  = 1'b0;
      s_tuser  = '0;
      m_tready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_s_tready", 32'(s_tready), 32'd0);
      check("rst_outputs", 32'({m_tvalid, m_tdata, m_tlast, m_tuser, status_empty_last}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // single full beat with tlast
      step(1'b1, 32'h44332211, 4'hF, 1'b1, 1'b0, 1'b1);
      idle(5);
      // two back-to-back beats, tuser on the second
      step(1'b1, 32'h88776655, 4'hF, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 32'hCCBBAA99, 4'hF, 1'b1, 1'b1, 1'b1);
      step(1'b1, 32'hCCBBAA99, 4'hF, 1'b1, 1'b1, 1'b1);
      idle(5);
      // sparse keep
      step(1'b1, 32'hDDCCBBAA, 4'b1010, 1'b1, 1'b0, 1'b1);
      idle(3);
      // stall pattern
      step(1'b1, 32'h04030201, 4'hF, 1'b1, 1'b0, 1'b1);
      step(1'b1, 32'h55555555, 4'hF, 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'h55555555, 4'hF, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h55555555, 4'hF, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h55555555, 4'hF, 1'b0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
      idle(6);
      // empty last beat, then a normal beat
      step(1'b1, 32'hFFFFFFFF, 4'h0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 32'h0000BEEF, 4'h3, 1'b1, 1'b0, 1'b1);
      idle(4);

      // reset while byte 2 of 4 is pending
      step(1'b1, 32'hA4A3A2A1, 4'hF, 1'b1, 1'b0, 1'b1);
      step(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
      check("midrst_s_tready", 32'(s_tready), 32'd0);
      q.delete();
      exp_pulse = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      idle(4);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         logic [3:0] k;
         k = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
         step(1'($urandom_range(0, 9) < 7), $urandom, k,
              1'($urandom), 1'($urandom), 1'($urandom_range(0, 9) < 7));
      end
      idle(10);
      check("drain_empty", 32'(q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
